// File: rtl/snappy_pkg.sv
// Shared types, tag constants and the token encoder for the Snappy token emitter.
package snappy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_CMD_WAIT,
        S_TAG,
        S_EXT,
        S_LIT
    } state_t;

    localparam logic [1:0]  TAG_LITERAL     = 2'b00;
    localparam logic [1:0]  TAG_COPY1       = 2'b01;
    localparam logic [1:0]  TAG_COPY2       = 2'b10;
    localparam logic        CMD_LITERAL     = 1'b0;
    localparam logic        CMD_COPY        = 1'b1;
    localparam logic [15:0] LIT_SHORT_MAX   = 16'd60;
    localparam logic [7:0]  LIT_TAG_EXT1    = 8'hF0;
    localparam logic [7:0]  LIT_TAG_EXT2    = 8'hF4;
    localparam logic [15:0] COPY1_OFF_LIMIT = 16'd2048;
    localparam logic [15:0] COPY_LEN_MAX    = 16'd64;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] ext0;
        logic [7:0] ext1;
        logic [1:0] n_ext;
    } token_t;

    function automatic logic cmd_legal(input logic ctype, input logic [15:0] len,
                                       input logic [15:0] off);
        if (ctype == CMD_LITERAL) return len != 16'd0;
        return (len != 16'd0) && (len <= COPY_LEN_MAX) && (off != 16'd0);
    endfunction

    // Only meaningful for legal commands, so len-1 never wraps.
    function automatic token_t encode_token(input logic ctype, input logic [15:0] len,
                                            input logic [15:0] off);
        token_t     t;
        logic [15:0] lm1;
        logic [2:0]  lm4;
        lm1     = len - 16'd1;
        lm4     = len[2:0] - 3'd4;
        t.tag   = {lm1[5:0], TAG_LITERAL};
        t.ext0  = lm1[7:0];
        t.ext1  = lm1[15:8];
        t.n_ext = 2'd0;
        if (ctype == CMD_LITERAL) begin
            if (lm1 < LIT_SHORT_MAX) begin
                t.n_ext = 2'd0;
            end else if (lm1 < 16'd256) begin
                t.tag   = LIT_TAG_EXT1;
                t.n_ext = 2'd1;
            end else begin
                t.tag   = LIT_TAG_EXT2;
                t.n_ext = 2'd2;
            end
        end else begin
            t.ext0 = off[7:0];
            t.ext1 = off[15:8];
            if (len >= 16'd4 && len <= 16'd11 && off < COPY1_OFF_LIMIT) begin
                t.tag   = {off[10:8], lm4, TAG_COPY1};
                t.n_ext = 2'd1;
            end else begin
                t.tag   = {lm1[5:0], TAG_COPY2};
                t.n_ext = 2'd2;
            end
        end
        return t;
    endfunction

endpackage

// File: rtl/snappy_varint_ser.sv
// Serialises a 32-bit value as a little-endian base-128 varint, one byte per ready.
module snappy_varint_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] value,
    output logic        valid,
    input  logic        ready,
    output logic [7:0]  data,
    output logic        last
);
    import snappy_pkg::*;

    logic [31:0] rem;
    logic        active;

    assign valid = active;
    assign last  = (rem[31:7] == 25'd0);
    assign data  = {~last, rem[6:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem    <= 32'd0;
            active <= 1'b0;
        end else if (load) begin
            rem    <= value;
            active <= 1'b1;
        end else if (active && ready) begin
            rem <= rem >> 7;
            if (last) active <= 1'b0;
        end
    end

endmodule

// File: rtl/snappy_token_emitter.sv
// Snappy token emitter: varint preamble, then literal/copy tokens from a command stream.
// Optional trace ports are added when SNAPPY_EMIT_TRACE_EN is defined.
module snappy_token_emitter
    import snappy_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] ulen_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_type_i,
    input  logic [15:0] cmd_len_i,
    input  logic [15:0] cmd_off_i,
    input  logic        cmd_last_i,
    input  logic        lit_valid_i,
    output logic        lit_ready_o,
    input  logic [7:0]  lit_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_data_o,
    output logic        out_last_o,
    output logic        busy_o,
    output logic        err_o
`ifdef SNAPPY_EMIT_TRACE_EN
    ,
    output logic [2:0]  trace_state_o,
    output logic        trace_lit_o,
    output logic        trace_copy_o
`endif
);

    // All ports are valid/ready: a transfer happens on the rising edge where both are 1;
    // a source holds its payload stable while valid=1 and ready=0.
    state_t     state;
    token_t     tok;
    logic       cmd_copy_q;
    logic       cmd_last_q;
    logic       ext_idx;
    logic [15:0] lit_cnt;
    logic       out_free;
    logic       ext_final;
    logic       ser_valid;
    logic       ser_last;
    logic [7:0] ser_data;
    token_t     enc;
    logic       enc_legal;

    assign out_free    = !out_valid_o || out_ready_i;
    assign cmd_ready_o = (state == S_CMD_WAIT);
    assign lit_ready_o = (state == S_LIT) && out_free;
    assign busy_o      = (state != S_IDLE);
    assign ext_final   = ext_idx || (tok.n_ext == 2'd1);
    assign enc         = encode_token(cmd_type_i, cmd_len_i, cmd_off_i);
    assign enc_legal   = cmd_legal(cmd_type_i, cmd_len_i, cmd_off_i);

    snappy_varint_ser u_varint (
        .clk   (clk),
        .rst_n (rst_n),
        .load  ((state == S_IDLE) && start_i),
        .value (ulen_i),
        .valid (ser_valid),
        .ready ((state == S_PREAMBLE) && out_free),
        .data  (ser_data),
        .last  (ser_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tok         <= '0;
            cmd_copy_q  <= 1'b0;
            cmd_last_q  <= 1'b0;
            ext_idx     <= 1'b0;
            lit_cnt     <= 16'd0;
            out_valid_o <= 1'b0;
            out_data_o  <= 8'd0;
            out_last_o  <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state <= S_PREAMBLE;
                        err_o <= 1'b0;
                    end
                end
                S_PREAMBLE: begin
                    if (ser_valid && out_free) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= ser_data;
                        out_last_o  <= 1'b0;
                        if (ser_last) state <= S_CMD_WAIT;
                    end
                end
                S_CMD_WAIT: begin
                    if (cmd_valid_i) begin
                        if (!enc_legal) begin
                            err_o <= 1'b1;
                            state <= cmd_last_i ? S_IDLE : S_CMD_WAIT;
                        end else begin
                            tok        <= enc;
                            cmd_copy_q <= cmd_type_i;
                            cmd_last_q <= cmd_last_i;
                            lit_cnt    <= cmd_len_i;
                            ext_idx    <= 1'b0;
                            state      <= S_TAG;
                        end
                    end
                end
                S_TAG: begin
                    if (out_free) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= tok.tag;
                        out_last_o  <= 1'b0;
                        state       <= (tok.n_ext != 2'd0) ? S_EXT : S_LIT;
                    end
                end
                S_EXT: begin
                    if (out_free) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= ext_idx ? tok.ext1 : tok.ext0;
                        out_last_o  <= cmd_copy_q && cmd_last_q && ext_final;
                        ext_idx     <= 1'b1;
                        if (ext_final) begin
                            if (cmd_copy_q) state <= cmd_last_q ? S_IDLE : S_CMD_WAIT;
                            else            state <= S_LIT;
                        end
                    end
                end
                S_LIT: begin
                    if (lit_valid_i && out_free) begin
                        out_valid_o <= 1'b1;
                        out_data_o  <= lit_data_i;
                        out_last_o  <= cmd_last_q && (lit_cnt == 16'd1);
                        lit_cnt     <= lit_cnt - 16'd1;
                        if (lit_cnt == 16'd1) state <= cmd_last_q ? S_IDLE : S_CMD_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SNAPPY_EMIT_TRACE_EN
    assign trace_state_o = (state == S_IDLE)     ? 3'd0 :
                           (state == S_PREAMBLE) ? 3'd1 : 3'd2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trace_lit_o  <= 1'b0;
            trace_copy_o <= 1'b0;
        end else begin
            trace_lit_o  <= (state == S_TAG) && out_free && !cmd_copy_q;
            trace_copy_o <= (state == S_TAG) && out_free && cmd_copy_q;
        end
    end
`endif

endmodule

// File: tb/tb_snappy_token_emitter.sv
// Bench for snappy_token_emitter: byte-level model queue plus directed literal checks.
module tb_snappy_token_emitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] ulen_i = 32'd0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_type_i = 1'b0;
    logic [15:0] cmd_len_i = 16'd0;
    logic [15:0] cmd_off_i = 16'd0;
    logic        cmd_last_i = 1'b0;
    logic        lit_valid_i = 1'b0;
    logic        lit_ready_o;
    logic [7:0]  lit_data_i = 8'd0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [7:0]  out_data_o;
    logic        out_last_o;
    logic        busy_o;
    logic        err_o;
`ifdef SNAPPY_EMIT_TRACE_EN
    logic [2:0]  trace_state_o;
    logic        trace_lit_o;
    logic        trace_copy_o;
`endif

    snappy_token_emitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .ulen_i      (ulen_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_type_i  (cmd_type_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_off_i   (cmd_off_i),
        .cmd_last_i  (cmd_last_i),
        .lit_valid_i (lit_valid_i),
        .lit_ready_o (lit_ready_o),
        .lit_data_i  (lit_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
`ifdef SNAPPY_EMIT_TRACE_EN
        ,
        .trace_state_o (trace_state_o),
        .trace_lit_o   (trace_lit_o),
        .trace_copy_o  (trace_copy_o)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  rx_q[$];
    int          lit_taken = 0;
    int          lit_target = 0;
    bit          abort = 1'b0;
    bit          bp_en = 1'b0;
    bit          stall = 1'b0;
    bit          hold_pending = 1'b0;
    logic [8:0]  held = 9'd0;

    // Output-ready generator: optional random backpressure or a forced stall.
    always @(posedge clk) begin
        #2;
        if (stall)      out_ready_i = 1'b0;
        else if (bp_en) out_ready_i = ($urandom_range(0, 3) != 0);
        else            out_ready_i = 1'b1;
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                checks++;
                if (!out_valid_o || {out_last_o, out_data_o} != held) begin
                    errors++;
                    $display("FAIL hold_stable got v=%0b %h want %h", out_valid_o,
                             {out_last_o, out_data_o}, held);
                end
            end
            if (out_valid_o && out_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_byte got %h want nothing", {out_last_o, out_data_o});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last_o, out_data_o} != e) begin
                        errors++;
                        $display("FAIL out_byte got last=%0b data=%h want last=%0b data=%h",
                                 out_last_o, out_data_o, e[8], e[7:0]);
                    end
                end
                rx_q.push_back({out_last_o, out_data_o});
            end
            if (lit_valid_i && lit_ready_o) lit_taken++;
            hold_pending = out_valid_o && !out_ready_i;
            held = {out_last_o, out_data_o};
        end
    end

    // ---------------- model ----------------
    task automatic exp_byte(input int b, input bit l);
        exp_q.push_back({l, b[7:0]});
    endtask

    task automatic exp_varint(input int unsigned v);
        int unsigned b;
        do begin
            b = v % 128;
            v = v / 128;
            exp_byte(int'(b) + ((v != 0) ? 128 : 0), 1'b0);
        end while (v != 0);
    endtask

    task automatic exp_literal(input int len, input bit last, input logic [7:0] base);
        int n = len - 1;
        if (len <= 60) begin
            exp_byte(n * 4, 1'b0);
        end else if (len <= 256) begin
            exp_byte(240, 1'b0);
            exp_byte(n, 1'b0);
        end else begin
            exp_byte(244, 1'b0);
            exp_byte(n % 256, 1'b0);
            exp_byte(n / 256, 1'b0);
        end
        for (int i = 0; i < len; i++) begin
            logic [7:0] d;
            d = base + i[7:0];
            exp_byte(int'(d), last && (i == len - 1));
        end
    endtask

    task automatic exp_copy(input int len, input int off, input bit last);
        if (len >= 4 && len <= 11 && off < 2048) begin
            exp_byte((off / 256) * 32 + (len - 4) * 4 + 1, 1'b0);
            exp_byte(off % 256, last);
        end else begin
            exp_byte((len - 1) * 4 + 2, 1'b0);
            exp_byte(off % 256, 1'b0);
            exp_byte(off / 256, last);
        end
    endtask

    // ---------------- helpers / drivers ----------------
    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic check_rx(input string name, input int idx, input logic [8:0] want);
        checks++;
        if (idx >= rx_q.size()) begin
            errors++;
            $display("FAIL %s got no byte at %0d want %h", name, idx, want);
        end else if (rx_q[idx] !== want) begin
            errors++;
            $display("FAIL %s got %h at %0d want %h", name, rx_q[idx], idx, want);
        end
    endtask

    // which: 0 cmd_ready, 1 lit_ready, 2 drained, 3 lit_taken reaches lit_target
    task automatic wait_for(input int which, input string what);
        bit ok = 1'b0;
        int n = 0;
        while (!ok && !abort) begin
            @(negedge clk);
            case (which)
                0:       ok = cmd_ready_o;
                1:       ok = lit_ready_o;
                2:       ok = (exp_q.size() == 0) && !out_valid_o;
                default: ok = (lit_taken >= lit_target);
            endcase
            n++;
            if (!ok && n > 5000) begin
                checks++;
                errors++;
                $display("FAIL timeout_%s got no event want event within 5000 cycles", what);
                return;
            end
        end
    endtask

    task automatic do_start(input logic [31:0] ulen);
        rx_q.delete();
        exp_varint(ulen);
        start_i = 1'b1;
        ulen_i  = ulen;
        @(posedge clk); #1;
        start_i = 1'b0;
        check_eq("busy_after_start", {31'd0, busy_o}, 32'd1);
        check_eq("err_clear_on_start", {31'd0, err_o}, 32'd0);
    endtask

    task automatic send_lit_bytes(input int len, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            if (abort) break;
            lit_valid_i = 1'b1;
            lit_data_i  = base + i[7:0];
            wait_for(1, "lit_ready");
            @(posedge clk); #1;
        end
        lit_valid_i = 1'b0;
    endtask

    task automatic send_cmd(input bit ctype, input int len, input int off, input bit last,
                            input logic [7:0] base);
        bit legal = ctype ? (len >= 1 && len <= 64 && off != 0) : (len != 0);
        if (legal) begin
            if (ctype) exp_copy(len, off, last);
            else       exp_literal(len, last, base);
        end
        cmd_valid_i = 1'b1;
        cmd_type_i  = ctype;
        cmd_len_i   = len[15:0];
        cmd_off_i   = off[15:0];
        cmd_last_i  = last;
        wait_for(0, "cmd_ready");
        @(posedge clk); #1;
        cmd_valid_i = 1'b0;
        if (!ctype && legal) send_lit_bytes(len, base);
    endtask

    task automatic drain_and_idle();
        wait_for(2, "drain");
        @(negedge clk);
        check_eq("busy_end", {31'd0, busy_o}, 32'd0);
    endtask

    task automatic check_reset_outs(input string name);
        check_eq(name, {25'd0, out_valid_o, out_data_o != 8'd0, out_last_o, cmd_ready_o,
                        lit_ready_o, busy_o, err_o}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset_outputs");
        check_eq("reset_data", {24'd0, out_data_o}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // preamble 300 and a short final literal
        do_start(32'd300);
        send_cmd(1'b0, 5, 0, 1'b1, 8'h61);
        drain_and_idle();
        check_rx("pre300_b0", 0, 9'h0AC);
        check_rx("pre300_b1", 1, 9'h002);
        check_rx("lit5_tag", 2, 9'h010);
        check_rx("lit5_d0", 3, 9'h061);
        check_rx("lit5_last", 7, 9'h165);
        check_eq("lit5_count", rx_q.size(), 32'd8);

        // copy and literal size boundaries under random backpressure
        bp_en = 1'b1;
        do_start(32'd0);
        send_cmd(1'b1, 4, 10, 1'b0, 8'h00);
        send_cmd(1'b1, 12, 10, 1'b0, 8'h00);
        send_cmd(1'b1, 8, 3000, 1'b0, 8'h00);
        send_cmd(1'b1, 11, 2047, 1'b0, 8'h00);
        send_cmd(1'b1, 64, 1, 1'b0, 8'h00);
        send_cmd(1'b1, 3, 5, 1'b0, 8'h00);
        send_cmd(1'b0, 60, 0, 1'b0, 8'h10);
        send_cmd(1'b0, 61, 0, 1'b0, 8'h20);
        send_cmd(1'b0, 256, 0, 1'b0, 8'h30);
        send_cmd(1'b0, 257, 0, 1'b0, 8'h40);
        send_cmd(1'b0, 100, 0, 1'b0, 8'h50);
        send_cmd(1'b0, 300, 0, 1'b1, 8'h00);
        drain_and_idle();
        bp_en = 1'b0;
        check_rx("pre0", 0, 9'h000);
        check_rx("copy4_tag", 1, 9'h001);
        check_rx("copy4_off", 2, 9'h00A);
        check_rx("copy12_tag", 3, 9'h02E);
        check_rx("copy8_tag", 6, 9'h01E);
        check_rx("copy8_lo", 7, 9'h0B8);
        check_rx("copy8_hi", 8, 9'h00B);
        check_rx("copy11_tag", 9, 9'h0FD);
        check_rx("copy64_tag", 11, 9'h0FE);
        check_rx("copy3_tag", 14, 9'h00A);
        check_rx("lit60_tag", 17, 9'h0EC);
        check_rx("lit61_ext", 79, 9'h03C);
        check_rx("lit256_ext", 142, 9'h0FF);
        check_rx("lit257_tag", 399, 9'h0F4);
        check_rx("lit257_hi", 401, 9'h001);
        check_rx("lit100_ext", 660, 9'h063);
        check_rx("lit300_tag", 761, 9'h0F4);
        check_rx("lit300_lo", 762, 9'h02B);
        check_rx("lit300_hi", 763, 9'h001);
        check_rx("lit300_last", 1063, 9'h12B);

        // illegal commands are consumed silently and flag err_o
        do_start(32'd5);
        send_cmd(1'b1, 4, 0, 1'b0, 8'h00);
        check_eq("err_after_off0", {31'd0, err_o}, 32'd1);
        send_cmd(1'b1, 4, 10, 1'b0, 8'h00);
        send_cmd(1'b1, 0, 10, 1'b0, 8'h00);
        send_cmd(1'b1, 65, 10, 1'b0, 8'h00);
        send_cmd(1'b0, 0, 0, 1'b1, 8'h00);
        drain_and_idle();
        check_eq("err_sticky", {31'd0, err_o}, 32'd1);
        check_eq("illegal_count", rx_q.size(), 32'd3);
        check_rx("after_err_tag", 1, 9'h001);
        check_rx("after_err_off", 2, 9'h00A);

        // 3-cycle output stall mid-literal
        do_start(32'd1);
        lit_target = lit_taken + 3;
        fork
            send_cmd(1'b0, 8, 0, 1'b1, 8'hA0);
            begin
                int snap;
                wait_for(3, "lit_progress");
                @(posedge clk); #1;
                stall = 1'b1;
                @(posedge clk); #3;
                snap = lit_taken;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("stall_lit_ready", {31'd0, lit_ready_o}, 32'd0);
                end
                check_eq("stall_no_consume", lit_taken, snap);
                stall = 1'b0;
            end
        join
        drain_and_idle();
        check_eq("stall_count", rx_q.size(), 32'd10);

        // reset during a maximal literal, then a clean restart
        do_start(32'hFFFF_FFFF);
        lit_target = lit_taken + 10;
        fork
            send_cmd(1'b0, 65535, 0, 1'b1, 8'h00);
            begin
                wait_for(3, "lit_progress");
                abort = 1'b1;
            end
        join
        abort = 1'b0;
        check_rx("pre_max_b0", 0, 9'h0FF);
        check_rx("pre_max_b4", 4, 9'h00F);
        check_rx("lit_max_tag", 5, 9'h0F4);
        check_rx("lit_max_lo", 6, 9'h0FE);
        check_rx("lit_max_hi", 7, 9'h0FF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset_outs("reset_mid_lit");
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(32'd300);
        send_cmd(1'b1, 4, 1, 1'b1, 8'h00);
        drain_and_idle();
        check_rx("restart_b0", 0, 9'h0AC);
        check_rx("restart_b1", 1, 9'h002);
        check_rx("restart_copy", 3, 9'h101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snappy_token_emitter.md
SNAPPY_TOKEN_EMITTER -- requirements
Module: snappy_token_emitter

Interface
REQ-001 SHALL have clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have start_i  in  1  begin new stream; ulen_i  in  32  uncompressed length for preamble.
REQ-003 SHALL have cmd_valid_i  in  1; cmd_ready_o  out  1; cmd_type_i  in  1  (0 literal, 1 copy); cmd_len_i  in  16  byte count; cmd_off_i  in  16  copy offset; cmd_last_i  in  1  final command of stream.
REQ-004 SHALL have lit_valid_i  in  1; lit_ready_o  out  1; lit_data_i  in  8  literal payload bytes.
REQ-005 SHALL have out_valid_o  out  1; out_ready_i  in  1; out_data_o  out  8  compressed byte; out_last_o  out  1  final byte of stream.
REQ-006 SHALL have busy_o  out  1  stream in progress; err_o  out  1  sticky illegal-command flag.

Function
REQ-007 SHALL implement states IDLE, PREAMBLE, CMD_WAIT, TAG, EXT, LIT, with transitions only as stated below.
REQ-008 IDLE: start_i=1 -> PREAMBLE, latch ulen_i, clear err_o, busy_o=1; start_i while busy_o=1 SHALL be ignored.
REQ-009 PREAMBLE: emit ulen as varint, 7-bit groups LSB first, bit7 set on all but the last byte, 1..5 bytes; then -> CMD_WAIT.
REQ-010 CMD_WAIT: cmd_ready_o=1 only in this state; a command transfers on cmd_valid_i & cmd_ready_o and is registered.
REQ-011 Literal, L=cmd_len_i: L-1<60 -> tag (L-1)<<2; L-1<256 -> tag 0xF0 plus 1 byte L-1; else tag 0xF4 plus 2 bytes L-1, little-endian.
REQ-012 Copy, len 4..11 and off<2048 -> tag {off[10:8],len-4,2'b01} plus 1 byte off[7:0]; otherwise tag ((len-1)<<2)|2'b10 plus 2 bytes off, little-endian.
REQ-013 Illegal commands: literal L=0; copy len 0 or >64; copy off 0. Such a command SHALL be consumed, emit no bytes and set err_o; with cmd_last_i=1 -> IDLE, otherwise -> CMD_WAIT.
REQ-014 TAG -> EXT (if extension bytes) -> LIT (literal only) -> CMD_WAIT; after the last byte of a cmd_last_i command -> IDLE with busy_o=0.
REQ-015 LIT: lit_ready_o = out-register free & state LIT; exactly L bytes consumed, forwarded unchanged.
REQ-016 Outputs SHALL be registered; 1-cycle latency from acceptance to out_valid_o; throughput 1 byte/cycle while out_ready_i=1.
REQ-017 While out_valid_o=1 & out_ready_i=0, out_data_o and out_last_o SHALL hold stable.
REQ-018 out_last_o=1 only on the final byte of a legal cmd_last_i command.
REQ-019 Length and offset arithmetic SHALL be 16-bit unsigned with no wrap; L=65535 SHALL encode 0xF4,0xFE,0xFF.

Reset
REQ-020 rst_n=0 SHALL force IDLE; out_valid_o, out_data_o, out_last_o, cmd_ready_o, lit_ready_o, busy_o, err_o all 0 at the next edge, including mid-token, with the partial token discarded.

Configuration
REQ-021 With SNAPPY_EMIT_TRACE_EN defined, SHALL add trace_state_o[2:0] (0 idle, 1 preamble, 2 token), trace_lit_o and trace_copy_o, each a 1-cycle pulse on the tag byte handshake; all reset to 0.
REQ-022 Without SNAPPY_EMIT_TRACE_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-023 Package snappy_pkg SHALL hold the state enum, tag-type codes (2'b00, 2'b01, 2'b10), constants 60, 0xF0, 0xF4, 2048 and 64, and the command type codes.
REQ-024 The varint preamble SHALL live in sub-module snappy_varint_ser (32-bit in, byte-stream out, valid/ready).

Verification
REQ-025 start_i, ulen_i=300 -> preamble bytes 0xAC, 0x02; ulen_i=0 -> 0x00.
REQ-026 Literal L=5, data 0x61..0x65, last -> 0x10,0x61,0x62,0x63,0x64,0x65; out_last_o on 0x65; then busy_o=0.
REQ-027 Copy len 4 off 10 -> 0x01,0x0A; copy len 12 off 10 -> 0x2E,0x0A,0x00; copy len 8 off 3000 -> 0x1E,0xB8,0x0B.
REQ-028 Literal L=100 -> 0xF0,0x63 then 100 data bytes; L=300 -> 0xF4,0x2B,0x01 then 300 data bytes.
REQ-029 out_ready_i=0 for 3 cycles mid-literal -> byte held, no lit_data_i consumed; copy off 0 -> err_o=1, zero bytes emitted, next command encodes normally.
REQ-030 rst_n=0 during LIT -> next cycle all outputs 0, state IDLE; a new start_i then produces a correct preamble.
